// File: rtl/tpm_mm_pkg.sv
// tpm_mm_pkg: shared state, command, response, handle and startup codes
package tpm_mm_pkg;
  typedef enum logic [2:0] {
    ST_POWER_OFF   = 3'd0,
    ST_INIT        = 3'd1,
    ST_STARTUP     = 3'd2,
    ST_OPERATIONAL = 3'd3,
    ST_SELF_TEST   = 3'd4,
    ST_FAILURE     = 3'd5,
    ST_SHUTDOWN    = 3'd6
  } op_state_e;
  localparam logic [31:0] CC_HIERARCHY_CONTROL = 32'h0000_0121;
  localparam logic [31:0] CC_INC_SELF_TEST     = 32'h0000_0142;
  localparam logic [31:0] CC_SELF_TEST         = 32'h0000_0143;
  localparam logic [31:0] CC_STARTUP           = 32'h0000_0144;
  localparam logic [31:0] CC_SHUTDOWN          = 32'h0000_0145;
  localparam logic [31:0] RC_SUCCESS    = 32'h0000_0000;
  localparam logic [31:0] RC_VALUE      = 32'h0000_0084;
  localparam logic [31:0] RC_INITIALIZE = 32'h0000_0100;
  localparam logic [31:0] RC_FAILURE    = 32'h0000_0101;
  localparam logic [31:0] RC_AUTH_TYPE  = 32'h0000_0124;
  localparam logic [31:0] RC_LOCALITY   = 32'h0000_0907;
  localparam logic [31:0] RH_OWNER       = 32'h4000_0001;
  localparam logic [31:0] RH_ENDORSEMENT = 32'h4000_000B;
  localparam logic [31:0] RH_PLATFORM    = 32'h4000_000C;
  localparam logic SU_CLEAR = 1'b0;
  localparam logic SU_STATE = 1'b1;
  localparam logic [2:0] SU_TYPE_NONE    = 3'd0;
  localparam logic [2:0] SU_TYPE_RESET   = 3'd1;
  localparam logic [2:0] SU_TYPE_RESTART = 3'd2;
  localparam logic [2:0] SU_TYPE_RESUME  = 3'd3;
endpackage

// File: rtl/tpm_mm_if.sv
// tpm_mm_if: command inputs and management outputs of the TPM management block
interface tpm_mm_if;
  logic        keyStart_n_i;
  logic [31:0] tpm_cc_i;
  logic [32:0] cmd_param_i;
  logic [15:0] orderlyInput_i;
  logic        initialized_i;
  logic [31:0] authHierarchy_i;
  logic [31:0] executionEng_rc_i;
  logic [7:0]  locality_i;
  logic [15:0] testsRun_i, testsPassed_i, untested_i;
  logic        nv_phEnableNV_i, nv_shEnable_i, nv_ehEnable_i;
  logic [2:0]  op_state_o;
  logic [2:0]  startup_type_o;
  logic [31:0] tpm_rc_o;
  logic        phEnable_o, phEnableNV_o, shEnable_o, ehEnable_o;
  logic [15:0] shutdownSave_o;
  modport slave (
    input  keyStart_n_i, tpm_cc_i, cmd_param_i, orderlyInput_i, initialized_i,
           authHierarchy_i, executionEng_rc_i, locality_i, testsRun_i,
           testsPassed_i, untested_i, nv_phEnableNV_i, nv_shEnable_i, nv_ehEnable_i,
    output op_state_o, startup_type_o, tpm_rc_o, phEnable_o, phEnableNV_o,
           shEnable_o, ehEnable_o, shutdownSave_o
  );
  modport master (
    output keyStart_n_i, tpm_cc_i, cmd_param_i, orderlyInput_i, initialized_i,
           authHierarchy_i, executionEng_rc_i, locality_i, testsRun_i,
           testsPassed_i, untested_i, nv_phEnableNV_i, nv_shEnable_i, nv_ehEnable_i,
    input  op_state_o, startup_type_o, tpm_rc_o, phEnable_o, phEnableNV_o,
           shEnable_o, ehEnable_o, shutdownSave_o
  );
endinterface

// File: rtl/tpm_mm_strobe_edge.sv
// tpm_mm_strobe_edge: registers the active-low strobe and flags one event per low pulse
module tpm_mm_strobe_edge (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic key_n_i,
  output logic event_o
);
  logic key_q;
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) key_q <= 1'b1;
    else            key_q <= key_n_i;
  assign event_o = key_q & ~key_n_i;
endmodule

// File: rtl/tpm_management_module.sv
// tpm_management_module: TPM lifecycle state, hierarchy enables and response codes
module tpm_management_module
  import tpm_mm_pkg::*;
(
  input logic     clock_i,
  input logic     reset_n_i,
  tpm_mm_if.slave bus
);
  logic        evt;
  op_state_e   state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] rc_q, rc_d;
  logic        ph_q, ph_d, phnv_q, phnv_d, sh_q, sh_d, eh_q, eh_d;
  logic [15:0] save_q, save_d;
  logic [1:0]  tgt;
  logic        st, hc_ok, unused_ok;
  tpm_mm_strobe_edge u_edge (
    .clock_i  (clock_i),
    .reset_n_i(reset_n_i),
    .key_n_i  (bus.keyStart_n_i),
    .event_o  (evt)
  );
  assign tgt = bus.cmd_param_i[2:1];
  assign st  = bus.cmd_param_i[0];
  // owner and endorsement may only disable their own hierarchy
  assign hc_ok = (bus.authHierarchy_i == RH_PLATFORM) ||
                 (bus.authHierarchy_i == RH_OWNER && tgt == 2'b01 && !st) ||
                 (bus.authHierarchy_i == RH_ENDORSEMENT && tgt == 2'b10 && !st);
  assign unused_ok = &{1'b0, bus.untested_i, bus.cmd_param_i[32:3]};
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    rc_d    = rc_q;
    ph_d    = ph_q;
    phnv_d  = phnv_q;
    sh_d    = sh_q;
    eh_d    = eh_q;
    save_d  = save_q;
    if (evt) begin
      case (state_q)
        ST_POWER_OFF: state_d = ST_INIT;
        ST_INIT:
          if (bus.tpm_cc_i != CC_STARTUP) rc_d = RC_INITIALIZE;
          else if (bus.locality_i > 8'd4) rc_d = RC_LOCALITY;
          else if (st == SU_STATE && bus.orderlyInput_i != 16'd1) rc_d = RC_VALUE;
          else begin
            state_d = ST_STARTUP;
            rc_d    = RC_SUCCESS;
            type_d  = (st == SU_STATE) ? SU_TYPE_RESUME :
                      (bus.orderlyInput_i == 16'd1) ? SU_TYPE_RESTART : SU_TYPE_RESET;
          end
        ST_STARTUP:
          if (!bus.initialized_i) rc_d = RC_INITIALIZE;
          else begin
            state_d = ST_OPERATIONAL;
            rc_d    = RC_SUCCESS;
            ph_d    = 1'b1;
            phnv_d  = bus.nv_phEnableNV_i;
            sh_d    = (type_q == SU_TYPE_RESUME) ? bus.nv_shEnable_i : 1'b1;
            eh_d    = (type_q == SU_TYPE_RESUME) ? bus.nv_ehEnable_i : 1'b1;
          end
        ST_OPERATIONAL:
          if (bus.tpm_cc_i == CC_SELF_TEST || bus.tpm_cc_i == CC_INC_SELF_TEST) begin
            state_d = ST_SELF_TEST;
            rc_d    = RC_SUCCESS;
          end else if (bus.tpm_cc_i == CC_SHUTDOWN) begin
            state_d = ST_SHUTDOWN;
            rc_d    = RC_SUCCESS;
            save_d  = {15'b0, st};
          end else if (bus.tpm_cc_i == CC_HIERARCHY_CONTROL) begin
            rc_d   = hc_ok ? RC_SUCCESS : RC_AUTH_TYPE;
            ph_d   = (hc_ok && tgt == 2'b00) ? st : ph_q;
            sh_d   = (hc_ok && tgt == 2'b01) ? st : sh_q;
            eh_d   = (hc_ok && tgt == 2'b10) ? st : eh_q;
            phnv_d = (hc_ok && tgt == 2'b11) ? st : phnv_q;
          end else rc_d = bus.executionEng_rc_i;
        ST_SELF_TEST: begin
          state_d = (bus.testsPassed_i == bus.testsRun_i) ? ST_OPERATIONAL : ST_FAILURE;
          rc_d    = (bus.testsPassed_i == bus.testsRun_i) ? RC_SUCCESS : RC_FAILURE;
        end
        ST_SHUTDOWN: begin
          state_d = ST_OPERATIONAL;
          rc_d    = RC_SUCCESS;
        end
        default: begin
          state_d = ST_FAILURE;
          rc_d    = RC_FAILURE;
        end
      endcase
    end
  end
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= ST_POWER_OFF;
      type_q  <= SU_TYPE_NONE;
      rc_q    <= RC_INITIALIZE;
      ph_q    <= 1'b0;
      phnv_q  <= 1'b0;
      sh_q    <= 1'b0;
      eh_q    <= 1'b0;
      save_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      rc_q    <= rc_d;
      ph_q    <= ph_d;
      phnv_q  <= phnv_d;
      sh_q    <= sh_d;
      eh_q    <= eh_d;
      save_q  <= save_d;
    end
  assign bus.op_state_o     = state_q;
  assign bus.startup_type_o = type_q;
  assign bus.tpm_rc_o       = rc_q;
  assign bus.phEnable_o     = ph_q;
  assign bus.phEnableNV_o   = phnv_q;
  assign bus.shEnable_o     = sh_q;
  assign bus.ehEnable_o     = eh_q;
  assign bus.shutdownSave_o = save_q;
endmodule

// File: tb/tb_tpm_management_module.sv
// tb_tpm_management_module: directed lifecycle walk with immediate-assertion checks
module tb_tpm_management_module;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  tpm_mm_if bus ();
  tpm_management_module dut (.clock_i(clk), .reset_n_i(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask
  task automatic strobe();
    @(negedge clk) bus.keyStart_n_i = 1'b0;
    @(negedge clk) bus.keyStart_n_i = 1'b1;
    @(negedge clk);
  endtask
  task automatic cmd(input logic [31:0] cc, input logic [32:0] prm);
    bus.tpm_cc_i    = cc;
    bus.cmd_param_i = prm;
    strobe();
  endtask
  task automatic enables(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, bus.phEnable_o, bus.phEnableNV_o, bus.shEnable_o, bus.ehEnable_o}, {28'd0, exp});
  endtask
  initial begin
    bus.keyStart_n_i = 1'b1;
    bus.tpm_cc_i = '0;
    bus.cmd_param_i = '0;
    bus.orderlyInput_i = '0;
    bus.initialized_i = 1'b0;
    bus.authHierarchy_i = '0;
    bus.executionEng_rc_i = 32'h0000_0922;
    bus.locality_i = '0;
    bus.testsRun_i = '0;
    bus.testsPassed_i = '0;
    bus.untested_i = 16'd3;
    bus.nv_phEnableNV_i = 1'b1;
    bus.nv_shEnable_i = 1'b1;
    bus.nv_ehEnable_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", {29'd0, bus.op_state_o}, 32'd0);
    chk("rst_rc", bus.tpm_rc_o, 32'h100);
    chk("rst_type", {29'd0, bus.startup_type_o}, 32'd0);
    enables("rst_en", 4'b0000);
    chk("rst_save", {16'd0, bus.shutdownSave_o}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", {29'd0, bus.op_state_o}, 32'd0);
    cmd(32'h145, '0);
    chk("poweroff_to_init", {29'd0, bus.op_state_o}, 32'd1);
    chk("poweroff_rc_kept", bus.tpm_rc_o, 32'h100);
    cmd(32'h145, '0);
    chk("init_badcc_state", {29'd0, bus.op_state_o}, 32'd1);
    chk("init_badcc_rc", bus.tpm_rc_o, 32'h100);
    cmd(32'h144, '0);
    chk("startup_state", {29'd0, bus.op_state_o}, 32'd2);
    chk("startup_type_reset", {29'd0, bus.startup_type_o}, 32'd1);
    chk("startup_rc", bus.tpm_rc_o, 32'h0);
    bus.initialized_i = 1'b1;
    cmd(32'h0, '0);
    chk("oper_state", {29'd0, bus.op_state_o}, 32'd3);
    chk("oper_rc", bus.tpm_rc_o, 32'h0);
    enables("oper_en", 4'b1111);
    bus.authHierarchy_i = 32'h4000_000C;
    cmd(32'h121, 33'd1);
    chk("hc_plat_state", {29'd0, bus.op_state_o}, 32'd3);
    chk("hc_plat_rc", bus.tpm_rc_o, 32'h0);
    enables("hc_plat_en", 4'b1111);
    cmd(32'h121, 33'b110);
    chk("hc_plat_clr_phnv_rc", bus.tpm_rc_o, 32'h0);
    enables("hc_plat_clr_phnv", 4'b1011);
    bus.authHierarchy_i = 32'h4000_0001;
    cmd(32'h121, 33'd1);
    chk("hc_owner_set_rc", bus.tpm_rc_o, 32'h124);
    enables("hc_owner_set_en", 4'b1011);
    cmd(32'h121, 33'b010);
    chk("hc_owner_clr_sh_rc", bus.tpm_rc_o, 32'h0);
    enables("hc_owner_clr_sh", 4'b1001);
    cmd(32'h121, 33'b100);
    chk("hc_owner_eh_rc", bus.tpm_rc_o, 32'h124);
    enables("hc_owner_eh_en", 4'b1001);
    bus.authHierarchy_i = 32'h4000_000B;
    cmd(32'h121, 33'b100);
    chk("hc_endo_clr_eh_rc", bus.tpm_rc_o, 32'h0);
    enables("hc_endo_clr_eh", 4'b1000);
    cmd(32'h121, 33'b101);
    chk("hc_endo_set_rc", bus.tpm_rc_o, 32'h124);
    enables("hc_endo_set_en", 4'b1000);
    cmd(32'h17F, '0);
    chk("other_cc_rc", bus.tpm_rc_o, 32'h922);
    chk("other_cc_state", {29'd0, bus.op_state_o}, 32'd3);
    repeat (3) @(negedge clk);
    chk("no_event_hold_rc", bus.tpm_rc_o, 32'h922);
    bus.testsRun_i = 16'd40;
    bus.testsPassed_i = 16'd40;
    cmd(32'h143, '0);
    chk("selftest_state", {29'd0, bus.op_state_o}, 32'd4);
    cmd(32'h0, '0);
    chk("selftest_pass_state", {29'd0, bus.op_state_o}, 32'd3);
    chk("selftest_pass_rc", bus.tpm_rc_o, 32'h0);
    cmd(32'h145, 33'd1);
    chk("shutdown_state", {29'd0, bus.op_state_o}, 32'd6);
    chk("shutdown_save", {16'd0, bus.shutdownSave_o}, 32'h1);
    cmd(32'h0, '0);
    chk("shutdown_exit", {29'd0, bus.op_state_o}, 32'd3);
    bus.testsPassed_i = 16'd37;
    cmd(32'h142, '0);
    chk("incst_state", {29'd0, bus.op_state_o}, 32'd4);
    cmd(32'h0, '0);
    chk("selftest_fail_state", {29'd0, bus.op_state_o}, 32'd5);
    chk("selftest_fail_rc", bus.tpm_rc_o, 32'h101);
    cmd(32'h145, '0);
    chk("failure_sticky_state", {29'd0, bus.op_state_o}, 32'd5);
    chk("failure_sticky_rc", bus.tpm_rc_o, 32'h101);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", {29'd0, bus.op_state_o}, 32'd0);
    chk("async_rst_rc", bus.tpm_rc_o, 32'h100);
    enables("async_rst_en", 4'b0000);
    chk("async_rst_save", {16'd0, bus.shutdownSave_o}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    bus.initialized_i = 1'b0;
    cmd(32'h0, '0);
    chk("rst2_init", {29'd0, bus.op_state_o}, 32'd1);
    bus.locality_i = 8'd5;
    cmd(32'h144, '0);
    chk("locality_rc", bus.tpm_rc_o, 32'h907);
    chk("locality_state", {29'd0, bus.op_state_o}, 32'd1);
    bus.locality_i = 8'd4;
    bus.orderlyInput_i = 16'd0;
    cmd(32'h144, 33'd1);
    chk("su_state_bad_rc", bus.tpm_rc_o, 32'h084);
    chk("su_state_bad_state", {29'd0, bus.op_state_o}, 32'd1);
    bus.orderlyInput_i = 16'd1;
    cmd(32'h144, 33'd1);
    chk("resume_state", {29'd0, bus.op_state_o}, 32'd2);
    chk("resume_type", {29'd0, bus.startup_type_o}, 32'd3);
    cmd(32'h0, '0);
    chk("notinit_state", {29'd0, bus.op_state_o}, 32'd2);
    chk("notinit_rc", bus.tpm_rc_o, 32'h100);
    bus.initialized_i = 1'b1;
    bus.nv_phEnableNV_i = 1'b0;
    bus.nv_shEnable_i = 1'b0;
    bus.nv_ehEnable_i = 1'b1;
    cmd(32'h0, '0);
    chk("resume_oper_state", {29'd0, bus.op_state_o}, 32'd3);
    enables("resume_en_nv", 4'b1001);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    cmd(32'h0, '0);
    cmd(32'h144, '0);
    chk("restart_type", {29'd0, bus.startup_type_o}, 32'd2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
